// File: rtl/nibble_serial_compare_ctrl.sv
// Serial magnitude comparator: one shared 4-bit slice walks the operands MS nibble first.
// Define SIGNED_CMP_EN for two's-complement operands (sign bit of the top nibble inverted).
module nibble_serial_compare_ctrl #(
  parameter int NIBBLES    = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  output logic                 busy,
  output logic                 done,
  output logic                 EQ,
  output logic                 ALB,
  output logic                 AGB,
  output logic [4:0]           CNT
);

  localparam int        W       = 4 * NIBBLES;
  localparam logic [3:0] TOP_IDX = 4'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t       state_reg;
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic [3:0]   idx_reg;
  logic         decided_reg;
  logic         dec_alb_reg;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic       slice_eq;
  logic       slice_alb;
  logic       decided_next;
  logic       dec_alb_next;
  logic       finish;

  // Nibble select for the shared slice.
  always_comb begin
    a_nib = 4'd0;
    b_nib = 4'd0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_reg == 4'(i)) begin
        a_nib = a_reg[4*i +: 4];
        b_nib = b_reg[4*i +: 4];
      end
    end
`ifdef SIGNED_CMP_EN
    // Flipping both sign bits maps two's complement onto unsigned ordering.
    if (idx_reg == TOP_IDX) begin
      a_nib[3] = ~a_nib[3];
      b_nib[3] = ~b_nib[3];
    end
`endif
  end

  assign slice_eq  = (a_nib == b_nib);
  assign slice_alb = (a_nib < b_nib);

  // The first unequal nibble decides; later nibbles never override it.
  assign decided_next = decided_reg | ~slice_eq;
  assign dec_alb_next = decided_reg ? dec_alb_reg : slice_alb;
  assign finish       = (idx_reg == 4'd0) || (EARLY_EXIT && !slice_eq && !decided_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      idx_reg     <= 4'd0;
      decided_reg <= 1'b0;
      dec_alb_reg <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      EQ          <= 1'b0;
      ALB         <= 1'b0;
      AGB         <= 1'b0;
      CNT         <= 5'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg       <= A;
            b_reg       <= B;
            idx_reg     <= TOP_IDX;
            decided_reg <= 1'b0;
            dec_alb_reg <= 1'b0;
            EQ          <= 1'b0;
            ALB         <= 1'b0;
            AGB         <= 1'b0;
            CNT         <= 5'd0;
            busy        <= 1'b1;
            state_reg   <= CMP;
          end
        end
        CMP: begin
          CNT         <= CNT + 5'd1;
          decided_reg <= decided_next;
          dec_alb_reg <= dec_alb_next;
          if (finish) begin
            EQ        <= ~decided_next;
            ALB       <= decided_next & dec_alb_next;
            AGB       <= decided_next & ~dec_alb_next;
            done      <= 1'b1;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg - 4'd1;
          end
        end
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_compare_ctrl.sv
// Scoreboard bench: three comparator instances (4 nibbles early/full walk, 1 nibble),
// expected results queued at issue time and checked by per-instance monitors on done.
module tb_nibble_serial_compare_ctrl;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  res;   // {EQ, ALB, AGB}
    int          cnt;
    int          lat;   // cycle (counted from the accepting edge) in which done is high
    int          acc;
  } exp_t;

  localparam logic [2:0] R_EQ = 3'b100;
  localparam logic [2:0] R_LT = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;
`ifdef SIGNED_CMP_EN
  localparam logic [2:0] R_9000_1FFF = R_LT;
  localparam logic [2:0] R_8000_0001 = R_LT;
`else
  localparam logic [2:0] R_9000_1FFF = R_GT;
  localparam logic [2:0] R_8000_0001 = R_GT;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic start, start_n1;
  logic [15:0] a_in, b_in;
  logic [3:0]  a_n1, b_n1;

  logic busy_e1, done_e1, eq_e1, alb_e1, agb_e1;
  logic busy_e0, done_e0, eq_e0, alb_e0, agb_e0;
  logic busy_n1, done_n1, eq_n1, alb_n1, agb_n1;
  logic [4:0] cnt_e1, cnt_e0, cnt_n1;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  exp_t q_e1[$];
  exp_t q_e0[$];
  exp_t q_n1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_compare_ctrl #(.NIBBLES(4), .EARLY_EXIT(1'b1)) dut_e1 (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .B(b_in),
    .busy(busy_e1), .done(done_e1), .EQ(eq_e1), .ALB(alb_e1), .AGB(agb_e1), .CNT(cnt_e1));

  nibble_serial_compare_ctrl #(.NIBBLES(4), .EARLY_EXIT(1'b0)) dut_e0 (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .B(b_in),
    .busy(busy_e0), .done(done_e0), .EQ(eq_e0), .ALB(alb_e0), .AGB(agb_e0), .CNT(cnt_e0));

  nibble_serial_compare_ctrl #(.NIBBLES(1), .EARLY_EXIT(1'b1)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .start(start_n1), .A(a_n1), .B(b_n1),
    .busy(busy_n1), .done(done_n1), .EQ(eq_n1), .ALB(alb_n1), .AGB(agb_n1), .CNT(cnt_n1));

  function automatic exp_t mk(input logic [15:0] a, input logic [15:0] b,
                              input logic [2:0] res, input int cnt, input int lat);
    exp_t e;
    e.a = a; e.b = b; e.res = res; e.cnt = cnt; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  task automatic check_txn(input string nm, input exp_t e, input logic [2:0] r, input logic [4:0] c);
    int lat;
    lat = cyc - e.acc + 1;
    $display("txn %s A=%h B=%h {EQ,ALB,AGB}=%b CNT=%0d done_cycle=%0d", nm, e.a, e.b, r, c, lat);
    checks++;
    if (r !== e.res) begin
      failures++;
      $display("FAIL %s result got=%b exp=%b", nm, r, e.res);
    end
    checks++;
    if (c !== 5'(e.cnt)) begin
      failures++;
      $display("FAIL %s cnt got=%0d exp=%0d", nm, c, e.cnt);
    end
    checks++;
    if (lat != e.lat) begin
      failures++;
      $display("FAIL %s latency got=%0d exp=%0d", nm, lat, e.lat);
    end
  endtask

  task automatic check_zero(input string nm, input logic [9:0] got);
    checks++;
    if (got !== 10'd0) begin
      failures++;
      $display("FAIL %s zero-state got=%b exp=%b", nm, got, 10'd0);
    end
  endtask

  task automatic check_bit(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", nm, got, exp);
    end
  endtask

  // Monitors: every done pulse must match the oldest queued expectation.
  always @(negedge clk) if (done_e1 === 1'b1) begin
    if (q_e1.size() == 0) begin
      checks++; failures++;
      $display("FAIL e1 unexpected done got=1 exp=0");
    end else check_txn("e1", q_e1.pop_front(), {eq_e1, alb_e1, agb_e1}, cnt_e1);
  end

  always @(negedge clk) if (done_e0 === 1'b1) begin
    if (q_e0.size() == 0) begin
      checks++; failures++;
      $display("FAIL e0 unexpected done got=1 exp=0");
    end else check_txn("e0", q_e0.pop_front(), {eq_e0, alb_e0, agb_e0}, cnt_e0);
  end

  always @(negedge clk) if (done_n1 === 1'b1) begin
    if (q_n1.size() == 0) begin
      checks++; failures++;
      $display("FAIL n1 unexpected done got=1 exp=0");
    end else check_txn("n1", q_n1.pop_front(), {eq_n1, alb_n1, agb_n1}, cnt_n1);
  end

  task automatic go4(input logic [15:0] a, input logic [15:0] b, input exp_t e1, input exp_t e0);
    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1;
    e1.acc = cyc + 1; e0.acc = cyc + 1;
    q_e1.push_back(e1);
    q_e0.push_back(e0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic go1(input logic [3:0] a, input logic [3:0] b, input logic [2:0] res);
    exp_t e;
    @(negedge clk);
    a_n1 = a; b_n1 = b; start_n1 = 1'b1;
    e = mk({12'd0, a}, {12'd0, b}, res, 1, 2);
    e.acc = cyc + 1;
    q_n1.push_back(e);
    @(negedge clk);
    start_n1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_e1 || busy_e0 || busy_n1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy_e1 || busy_e0 || busy_n1) begin
      failures++;
      $display("FAIL wait_idle busy got=%b%b%b exp=000", busy_e1, busy_e0, busy_n1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; start_n1 = 1'b0;
    a_in = '0; b_in = '0; a_n1 = '0; b_n1 = '0;
    repeat (3) @(negedge clk);
    check_zero("reset_e1", {busy_e1, done_e1, eq_e1, alb_e1, agb_e1, cnt_e1});
    check_zero("reset_e0", {busy_e0, done_e0, eq_e0, alb_e0, agb_e0, cnt_e0});
    check_zero("reset_n1", {busy_n1, done_n1, eq_n1, alb_n1, agb_n1, cnt_n1});
    rst_n = 1'b1;
    @(negedge clk);

    // Equal operands walk every nibble.
    go4(16'h1234, 16'h1234, mk(16'h1234, 16'h1234, R_EQ, 4, 5), mk(16'h1234, 16'h1234, R_EQ, 4, 5));
    wait_idle();

    // Top nibble decides: early exit vs full walk.
    go4(16'h9000, 16'h1FFF, mk(16'h9000, 16'h1FFF, R_9000_1FFF, 1, 2),
        mk(16'h9000, 16'h1FFF, R_9000_1FFF, 4, 5));
    wait_idle();

    // Last nibble decides; start during CMP and DONE ignored, next IDLE start accepted.
    @(negedge clk);
    a_in = 16'h1230; b_in = 16'h1231; start = 1'b1;
    begin
      exp_t e;
      e = mk(16'h1230, 16'h1231, R_LT, 4, 5);
      e.acc = cyc + 1;
      q_e1.push_back(e);
      q_e0.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a_in = 16'h0000; b_in = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_bit("busy_in_cmp", busy_e1, 1'b1);
    for (int i = 0; i < 10 && !done_e1; i++) @(negedge clk);
    check_bit("done_seen", done_e1, 1'b1);
    a_in = 16'hFFFF; b_in = 16'h0000; start = 1'b1;
    check_bit("busy_in_done", busy_e1, 1'b1);
    @(negedge clk);
    check_bit("idle_after_done_e1", busy_e1, 1'b0);
    check_bit("idle_after_done_e0", busy_e0, 1'b0);
    a_in = 16'h0005; b_in = 16'h0003;
    begin
      exp_t e;
      e = mk(16'h0005, 16'h0003, R_GT, 4, 5);
      e.acc = cyc + 1;
      q_e1.push_back(e);
      q_e0.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    check_bit("accepted_after_done", busy_e1, 1'b1);
    wait_idle();

    // Sign bit of the top nibble.
    go4(16'h8000, 16'h0001, mk(16'h8000, 16'h0001, R_8000_0001, 1, 2),
        mk(16'h8000, 16'h0001, R_8000_0001, 4, 5));
    wait_idle();

    // Reset during the second CMP cycle aborts without a done pulse.
    @(negedge clk);
    a_in = 16'h0000; b_in = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_bit("busy_before_abort", busy_e1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("abort_e1", {busy_e1, done_e1, eq_e1, alb_e1, agb_e1, cnt_e1});
    check_zero("abort_e0", {busy_e0, done_e0, eq_e0, alb_e0, agb_e0, cnt_e0});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    go4(16'h0005, 16'h0003, mk(16'h0005, 16'h0003, R_GT, 4, 5), mk(16'h0005, 16'h0003, R_GT, 4, 5));
    wait_idle();

    // Single-nibble instance, back-to-back starts.
    go1(4'hF, 4'hE, R_GT);
    go1(4'h3, 4'h7, R_LT);
    go1(4'h9, 4'h9, R_EQ);
    wait_idle();

    repeat (5) @(negedge clk);
    checks++;
    if (q_e1.size() + q_e0.size() + q_n1.size() != 0) begin
      failures++;
      $display("FAIL pending_txns got=%0d exp=0", q_e1.size() + q_e0.size() + q_n1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
